result_banner_ctrl: RTL and testbench

Sequences the end-of-game result banner on the VGA overlay. On a game-over event it latches which text to show (X WINS / O WINS / TIE) and drives the origin coordinates and enable for the text-drawing blocks. It slides the banner down from the top of the screen one step per frame, then holds it, optionally blinking, until restart. It sits between the game-logic FSM and the text renderers, and its outputs feed their `x`/`y` origin inputs.

---
 rtl/xo_pkg.sv | 22 ++
 rtl/frame_counter.sv | 34 +++
 rtl/result_banner_ctrl.sv | 144 ++++++++++++++
 tb/tb_result_banner_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xo_pkg.sv
// Purpose: shared result encoding, screen geometry and banner state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xo_pkg;

  // Result codes as driven by the game FSM.
  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_X    = 2'd1;
  localparam logic [1:0] RES_O    = 2'd2;
  localparam logic [1:0] RES_TIE  = 2'd3;

  // Visible screen area in pixels.
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLIDE = 2'd1,
    ST_HOLD  = 2'd2
  } banner_state_t;

endpackage

// File: rtl/frame_counter.sv
// Purpose: 6-bit frame counter with clear; emits a wrap pulse on its MAX-th tick.
// Latency: wrap is combinational with the tick that completes the count.
// Backpressure: none; ticks are never stalled.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear, wins over tick
//   tick     : count enable
//   wrap     : high during the tick that brings the count to MAX (count returns to 0)
module frame_counter #(
  parameter int MAX = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic wrap
);

  logic [5:0] count;

  assign wrap = tick && !clr && (count == 6'(MAX - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 6'd0;
    end else if (wrap) begin
      count <= 6'd0;
    end else if (tick) begin
      count <= count + 6'd1;
    end
  end

endmodule

// File: rtl/result_banner_ctrl.sv
// Purpose: sequences the game-over banner: latch result, slide origin down per frame, hold (optionally blinking).
// Latency: all outputs registered; game_over/frame_tick/restart take effect on the next cycle.
// Backpressure: none; pulses are consumed in the cycle they arrive or ignored.
//
// Ports:
//   clk, rst             : pixel clock, synchronous active-high reset
//   frame_tick           : one pulse per frame (vsync start)
//   game_over, result    : game-end pulse and result code (sampled only with game_over)
//   restart              : returns the banner to IDLE
//   banner_x, banner_y   : text origin for the renderers
//   text_sel             : latched result code
//   banner_en            : renderer draw enable
//   settled              : high while holding at the target
// Build option: define RESULT_BANNER_BLINK_EN to blink the banner while holding.
module result_banner_ctrl
  import xo_pkg::*;
#(
  parameter int X_POS        = 202,
  parameter int Y_START      = 0,
  parameter int Y_TARGET     = 188,
  parameter int STEP         = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       game_over,
  input  logic [1:0] result,
  input  logic       restart,
  output logic [9:0] banner_x,
  output logic [8:0] banner_y,
  output logic [1:0] text_sel,
  output logic       banner_en,
  output logic       settled
);

  // Catch out-of-range configurations at elaboration.
  if (STEP < 1 || STEP > 63) begin : g_bad_step
    $error("result_banner_ctrl: STEP out of range 1..63");
  end
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 63) begin : g_bad_blink
    $error("result_banner_ctrl: BLINK_FRAMES out of range 1..63");
  end

  banner_state_t state, state_nxt;
  logic [8:0]    y_nxt;
  logic [1:0]    sel_nxt;
  logic [9:0]    y_sum;
  logic          start;
  logic          blink_on;
  logic          blink_nxt;

  // One bit wider than banner_y so a step past 511 cannot wrap below the target.
  assign y_sum = {1'b0, banner_y} + 10'(STEP);

  // game_over only starts a banner from IDLE and only with a real result.
  assign start = (state == ST_IDLE) && game_over && (result != RES_NONE);

`ifdef RESULT_BANNER_BLINK_EN
  logic blink_wrap;

  frame_counter #(
    .MAX (BLINK_FRAMES)
  ) u_blink_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (restart || start),
    .tick (frame_tick && (state == ST_HOLD) && !restart),
    .wrap (blink_wrap)
  );

  // Each new banner starts in the visible phase.
  assign blink_nxt = (restart || start) ? 1'b1 :
                     blink_wrap         ? ~blink_on : blink_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_on <= 1'b1;
    end else begin
      blink_on <= blink_nxt;
    end
  end
`else
  assign blink_on  = 1'b1;
  assign blink_nxt = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    y_nxt     = banner_y;
    sel_nxt   = text_sel;
    if (restart) begin
      state_nxt = ST_IDLE;
      y_nxt     = 9'(Y_START);
      sel_nxt   = RES_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_SLIDE;
            y_nxt     = 9'(Y_START);
            sel_nxt   = result;
          end
        end
        ST_SLIDE: begin
          if (frame_tick) begin
            if (y_sum >= 10'(Y_TARGET)) begin
              y_nxt     = 9'(Y_TARGET);
              state_nxt = ST_HOLD;
            end else begin
              y_nxt = y_sum[8:0];
            end
          end
        end
        ST_HOLD: begin
          state_nxt = ST_HOLD;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      banner_x  <= 10'(X_POS);
      banner_y  <= 9'(Y_START);
      text_sel  <= RES_NONE;
      banner_en <= 1'b0;
      settled   <= 1'b0;
    end else begin
      state     <= state_nxt;
      banner_x  <= 10'(X_POS);
      banner_y  <= y_nxt;
      text_sel  <= sel_nxt;
      // Registered from next-state values so the enable lines up with the state it describes.
      banner_en <= (state_nxt != ST_IDLE) && ((state_nxt != ST_HOLD) || blink_nxt);
      settled   <= (state_nxt == ST_HOLD);
    end
  end

endmodule

// File: tb/tb_result_banner_ctrl.sv
// Purpose: self-checking bench for result_banner_ctrl (default and clamped-start configurations).
// Latency: outputs checked 1 ns after the edge that follows each stimulus cycle.
// Backpressure: n/a.
module tb_result_banner_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] result = 2'd0;
  logic       restart = 1'b0;
  logic [9:0] banner_x;
  logic [8:0] banner_y;
  logic [1:0] text_sel;
  logic       banner_en;
  logic       settled;

  logic       frame_tick2 = 1'b0;
  logic       game_over2 = 1'b0;
  logic [1:0] result2 = 2'd0;
  logic       restart2 = 1'b0;
  logic [9:0] banner_x2;
  logic [8:0] banner_y2;
  logic [1:0] text_sel2;
  logic       banner_en2;
  logic       settled2;

  int total = 0;
  int bad   = 0;

  // Expected {x, y, en, settled, sel}, pushed at stimulus time.
  logic [22:0] exp_q[$];
  logic [22:0] got;
  logic [22:0] exp_v;

  always #5 clk = ~clk;

  result_banner_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .game_over  (game_over),
    .result     (result),
    .restart    (restart),
    .banner_x   (banner_x),
    .banner_y   (banner_y),
    .text_sel   (text_sel),
    .banner_en  (banner_en),
    .settled    (settled)
  );

  result_banner_ctrl #(
    .Y_START  (200),
    .Y_TARGET (188)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick2),
    .game_over  (game_over2),
    .result     (result2),
    .restart    (restart2),
    .banner_x   (banner_x2),
    .banner_y   (banner_y2),
    .text_sel   (text_sel2),
    .banner_en  (banner_en2),
    .settled    (settled2)
  );

  function automatic logic [22:0] pk(input logic [9:0] x, input logic [8:0] y,
                                     input logic en, input logic st, input logic [1:0] sel);
    return {x, y, en, st, sel};
  endfunction

  // Drive one cycle of stimulus on the main DUT, then release all pulses.
  task automatic drive(input logic go, input logic [1:0] res, input logic ft,
                       input logic rs, input logic r);
    game_over  = go;
    result     = res;
    frame_tick = ft;
    restart    = rs;
    rst        = r;
    @(posedge clk);
    #1;
    game_over  = 1'b0;
    result     = 2'd0;
    frame_tick = 1'b0;
    restart    = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(pk(10'd202, 9'd0, 1'b0, 1'b0, 2'd0));
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    got = {banner_x, banner_y, banner_en, settled, text_sel};
    exp_v = exp_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL reset: got=%h want=%h", got, exp_v);
    end
    got = {banner_x2, banner_y2, banner_en2, settled2, text_sel2};
    exp_v = pk(10'd202, 9'd200, 1'b0, 1'b0, 2'd0);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL reset_dut2: got=%h want=%h", got, exp_v);
    end
  endtask

  task automatic test_idle_ignores();
    // game_over with no result, then restart beating game_over: both leave IDLE untouched.
    exp_q.push_back(pk(10'd202, 9'd0, 1'b0, 1'b0, 2'd0));
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(pk(10'd202, 9'd0, 1'b0, 1'b0, 2'd0));
    drive(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(pk(10'd202, 9'd0, 1'b0, 1'b0, 2'd0));
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    // Only the last cycle's result is still on the outputs; earlier entries were
    // held constant, so compare the latest against each queued value.
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got = {banner_x, banner_y, banner_en, settled, text_sel};
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL idle_ignore: got=%h want=%h", got, exp_v);
      end
    end
  endtask

  task automatic test_start();
    // frame_tick together with game_over must not advance y.
    exp_q.push_back(pk(10'd202, 9'd0, 1'b1, 1'b0, 2'd3));
    drive(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    got = {banner_x, banner_y, banner_en, settled, text_sel};
    exp_v = exp_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL start: got=%h want=%h", got, exp_v);
    end
  endtask

  task automatic test_slide();
    for (int k = 1; k <= 47; k++) begin
      if (k == 10) begin
        // Late game_over in SLIDE is ignored: y and text_sel unchanged.
        exp_q.push_back(pk(10'd202, 9'd36, 1'b1, 1'b0, 2'd3));
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        got = {banner_x, banner_y, banner_en, settled, text_sel};
        exp_v = exp_q.pop_front();
        total++;
        if (got !== exp_v) begin
          bad++;
          $display("FAIL slide_go_ignored: got=%h want=%h", got, exp_v);
        end
      end
      if (k < 47) exp_q.push_back(pk(10'd202, 9'(4 * k), 1'b1, 1'b0, 2'd3));
      else        exp_q.push_back(pk(10'd202, 9'd188, 1'b1, 1'b1, 2'd3));
      drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      got = {banner_x, banner_y, banner_en, settled, text_sel};
      exp_v = exp_q.pop_front();
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL slide_tick%0d: got=%h want=%h", k, got, exp_v);
      end
    end
  endtask

  task automatic test_hold_blink();
`ifdef RESULT_BANNER_BLINK_EN
    for (int k = 1; k <= 60; k++) begin
      exp_q.push_back(pk(10'd202, 9'd188, (k < 30) || (k >= 60), 1'b1, 2'd3));
      drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      got = {banner_x, banner_y, banner_en, settled, text_sel};
      exp_v = exp_q.pop_front();
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL blink_tick%0d: got=%h want=%h", k, got, exp_v);
      end
    end
`else
    for (int k = 1; k <= 100; k++) begin
      exp_q.push_back(pk(10'd202, 9'd188, 1'b1, 1'b1, 2'd3));
      drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      got = {banner_x, banner_y, banner_en, settled, text_sel};
      exp_v = exp_q.pop_front();
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL hold_tick%0d: got=%h want=%h", k, got, exp_v);
      end
    end
`endif
  endtask

  task automatic test_rst_in_hold();
    exp_q.push_back(pk(10'd202, 9'd0, 1'b0, 1'b0, 2'd0));
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    got = {banner_x, banner_y, banner_en, settled, text_sel};
    exp_v = exp_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL rst_in_hold: got=%h want=%h", got, exp_v);
    end
  endtask

  task automatic test_restart_mid_slide();
    drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 25; k++) drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(pk(10'd202, 9'd100, 1'b1, 1'b0, 2'd2));
    got = {banner_x, banner_y, banner_en, settled, text_sel};
    exp_v = exp_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL slide_to_100: got=%h want=%h", got, exp_v);
    end
    // Restart together with a tick; y after restart is not checked.
    drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    total++;
    if ({banner_x, banner_en, settled, text_sel} !== {10'd202, 1'b0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL restart_mid: got x=%0d en=%b st=%b sel=%0d want x=202 en=0 st=0 sel=0",
               banner_x, banner_en, settled, text_sel);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(pk(10'd202, 9'd0, 1'b1, 1'b0, 2'd1));
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(pk(10'd202, 9'd4, 1'b1, 1'b0, 2'd1));
    got = {banner_x, banner_y, banner_en, settled, text_sel};
    exp_v = exp_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL b2b_start: got=%h want=%h", got, exp_v);
    end
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    got = {banner_x, banner_y, banner_en, settled, text_sel};
    exp_v = exp_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL b2b_tick: got=%h want=%h", got, exp_v);
    end
  endtask

  task automatic test_clamp_start();
    game_over2 = 1'b1;
    result2    = 2'd2;
    exp_q.push_back(pk(10'd202, 9'd200, 1'b1, 1'b0, 2'd2));
    @(posedge clk);
    #1;
    game_over2 = 1'b0;
    result2    = 2'd0;
    got = {banner_x2, banner_y2, banner_en2, settled2, text_sel2};
    exp_v = exp_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL clamp_start: got=%h want=%h", got, exp_v);
    end
    frame_tick2 = 1'b1;
    exp_q.push_back(pk(10'd202, 9'd188, 1'b1, 1'b1, 2'd2));
    @(posedge clk);
    #1;
    frame_tick2 = 1'b0;
    got = {banner_x2, banner_y2, banner_en2, settled2, text_sel2};
    exp_v = exp_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL clamp_tick: got=%h want=%h", got, exp_v);
    end
    restart2 = 1'b1;
    @(posedge clk);
    #1;
    restart2 = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_idle_ignores();
    test_start();
    test_slide();
    test_hold_blink();
    test_rst_in_hold();
    test_restart_mid_slide();
    test_back_to_back();
    test_clamp_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
